led_frame_sched: RTL and testbench

//  Frame scheduler in front of the LED transmit FIFO, fast clock domain (150 MHz).

---
 rtl/led_frame_sched.sv | 156 +++++++++++++++
 tb/tb_led_frame_sched.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_sched.sv
// Frame scheduler: arbitrates cap/cpu word streams into the LED FIFO, writes LED_NUM words
// per frame, pulses send_start, then enforces the frame interval and the send_done timeout.
module led_frame_sched #(
   parameter int unsigned LED_NUM   = 47,
   parameter int unsigned FRAME_GAP = 2500000,
   parameter int unsigned DONE_TO   = 4000000,
   parameter int unsigned PRIO_MODE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        cap_req,
   output logic        cap_gnt,
   input  logic        cap_valid,
   input  logic [11:0] cap_data,
   output logic        cap_ready,
   input  logic        cpu_req,
   output logic        cpu_gnt,
   input  logic        cpu_valid,
   input  logic [11:0] cpu_data,
   output logic        cpu_ready,
   input  logic        fifo_afull,
   output logic        fifo_we,
   output logic [11:0] fifo_data,
   output logic        send_start,
   input  logic        send_done,
   output logic        busy,
   output logic        err_timeout
);

   localparam int unsigned WordW = $clog2(LED_NUM + 1);
   localparam int unsigned GapW  = $clog2(FRAME_GAP + 1);
   localparam int unsigned ToW   = $clog2(DONE_TO + 1);

   typedef enum logic [1:0] {StIdle, StStream, StLaunch, StWaitDone} state_e;

   state_e             state_q, state_d;
   logic               cap_gnt_q, cap_gnt_d;
   logic               cpu_gnt_q, cpu_gnt_d;
   logic               prio_cap_q, prio_cap_d;
   logic               fifo_we_q, fifo_we_d;
   logic [11:0]        fifo_data_q, fifo_data_d;
   logic               send_start_q, send_start_d;
   logic               err_q, err_d;
   logic [WordW-1:0]   word_cnt_q, word_cnt_d;
   logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [ToW-1:0]     to_cnt_q, to_cnt_d;

   logic               cap_xfer;
   logic               cpu_xfer;
   logic               pick_cpu;

   // Grants are only ever high in StStream, so they double as the stream-state qualifier.
   assign cap_xfer = cap_gnt_q & cap_valid & ~fifo_afull;
   assign cpu_xfer = cpu_gnt_q & cpu_valid & ~fifo_afull;

   always_comb begin
      state_d      = state_q;
      cap_gnt_d    = cap_gnt_q;
      cpu_gnt_d    = cpu_gnt_q;
      prio_cap_d   = prio_cap_q;
      fifo_we_d    = 1'b0;
      fifo_data_d  = fifo_data_q;
      send_start_d = 1'b0;
      err_d        = err_q;
      word_cnt_d   = word_cnt_q;
      to_cnt_d     = to_cnt_q;
      gap_cnt_d    = (gap_cnt_q == '0) ? '0 : gap_cnt_q - GapW'(1);
      pick_cpu     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (en && (gap_cnt_q == '0) && (cap_req || cpu_req)) begin
               pick_cpu   = cpu_req && (!cap_req || (PRIO_MODE == 1) || !prio_cap_q);
               cpu_gnt_d  = pick_cpu;
               cap_gnt_d  = !pick_cpu;
               prio_cap_d = pick_cpu;
               word_cnt_d = '0;
               state_d    = StStream;
            end
         end
         StStream: begin
            if (cap_xfer || cpu_xfer) begin
               fifo_we_d   = 1'b1;
               fifo_data_d = cpu_gnt_q ? cpu_data : cap_data;
               if (word_cnt_q == WordW'(LED_NUM - 1)) begin
                  // Last word: send_start lands together with its fifo_we.
                  word_cnt_d   = '0;
                  cap_gnt_d    = 1'b0;
                  cpu_gnt_d    = 1'b0;
                  send_start_d = 1'b1;
                  gap_cnt_d    = GapW'(FRAME_GAP - 1);
                  state_d      = StLaunch;
               end else begin
                  word_cnt_d = word_cnt_q + WordW'(1);
               end
            end
         end
         StLaunch: begin
            word_cnt_d = '0;
            to_cnt_d   = ToW'(1);
            state_d    = StWaitDone;
         end
         StWaitDone: begin
            if (send_done) begin
               state_d = StIdle;
            end else if (to_cnt_q >= ToW'(DONE_TO - 1)) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               to_cnt_d = to_cnt_q + ToW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         cap_gnt_q    <= 1'b0;
         cpu_gnt_q    <= 1'b0;
         prio_cap_q   <= 1'b1;
         fifo_we_q    <= 1'b0;
         fifo_data_q  <= '0;
         send_start_q <= 1'b0;
         err_q        <= 1'b0;
         word_cnt_q   <= '0;
         gap_cnt_q    <= '0;
         to_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         cap_gnt_q    <= cap_gnt_d;
         cpu_gnt_q    <= cpu_gnt_d;
         prio_cap_q   <= prio_cap_d;
         fifo_we_q    <= fifo_we_d;
         fifo_data_q  <= fifo_data_d;
         send_start_q <= send_start_d;
         err_q        <= err_d;
         word_cnt_q   <= word_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         to_cnt_q     <= to_cnt_d;
      end
   end

   assign cap_gnt     = cap_gnt_q;
   assign cpu_gnt     = cpu_gnt_q;
   assign cap_ready   = cap_gnt_q & ~fifo_afull;
   assign cpu_ready   = cpu_gnt_q & ~fifo_afull;
   assign fifo_we     = fifo_we_q;
   assign fifo_data   = fifo_data_q;
   assign send_start  = send_start_q;
   assign busy        = (state_q != StIdle);
   assign err_timeout = err_q;

endmodule

// File: tb/tb_led_frame_sched.sv
// Bench for led_frame_sched: scoreboard on the FIFO write port plus per-feature scenario tasks.
module tb_led_frame_sched;

   localparam int unsigned LedNum   = 47;
   localparam int unsigned FrameGap = 1000;
   localparam int unsigned DoneTo   = 500;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        cap_req = 1'b0, cpu_req = 1'b0;
   logic        cap_valid = 1'b1, cpu_valid = 1'b1;
   logic [11:0] cap_data = '0, cpu_data = '0;
   logic        fifo_afull = 1'b0;
   logic        send_done = 1'b0;

   logic        cap_gnt, cpu_gnt, cap_ready, cpu_ready, fifo_we, send_start, busy, err_timeout;
   logic [11:0] fifo_data;
   logic        rr_cap_gnt, rr_cpu_gnt, rr_cap_ready, rr_cpu_ready, rr_fifo_we;
   logic        rr_send_start, rr_busy, rr_err;
   logic [11:0] rr_fifo_data;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          starts = 0;
   int          start_cyc = 0;
   int          frame_words = 0;
   bit          valid_rand = 1'b0;
   logic [11:0] sb_q[$];

   led_frame_sched #(.LED_NUM(LedNum), .FRAME_GAP(FrameGap), .DONE_TO(DoneTo), .PRIO_MODE(1))
   u_dut (
      .clk(clk), .rst(rst), .en(en),
      .cap_req(cap_req), .cap_gnt(cap_gnt), .cap_valid(cap_valid), .cap_data(cap_data),
      .cap_ready(cap_ready),
      .cpu_req(cpu_req), .cpu_gnt(cpu_gnt), .cpu_valid(cpu_valid), .cpu_data(cpu_data),
      .cpu_ready(cpu_ready),
      .fifo_afull(fifo_afull), .fifo_we(fifo_we), .fifo_data(fifo_data),
      .send_start(send_start), .send_done(send_done), .busy(busy), .err_timeout(err_timeout)
   );

   led_frame_sched #(.LED_NUM(LedNum), .FRAME_GAP(FrameGap), .DONE_TO(DoneTo), .PRIO_MODE(0))
   u_dut_rr (
      .clk(clk), .rst(rst), .en(en),
      .cap_req(cap_req), .cap_gnt(rr_cap_gnt), .cap_valid(cap_valid), .cap_data(cap_data),
      .cap_ready(rr_cap_ready),
      .cpu_req(cpu_req), .cpu_gnt(rr_cpu_gnt), .cpu_valid(cpu_valid), .cpu_data(cpu_data),
      .cpu_ready(rr_cpu_ready),
      .fifo_afull(fifo_afull), .fifo_we(rr_fifo_we), .fifo_data(rr_fifo_data),
      .send_start(rr_send_start), .send_done(send_done), .busy(rr_busy), .err_timeout(rr_err)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      cap_data  = 12'($urandom);
      cpu_data  = 12'($urandom);
      cap_valid = valid_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      cpu_valid = valid_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   // Scoreboard: accepted words are pushed, FIFO writes popped; frame length checked at send_start.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         frame_words = 0;
      end else begin
         if (fifo_we) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL sb_extra_write: got %h, expected no write", fifo_data);
            end else begin
               logic [11:0] exp;
               exp = sb_q.pop_front();
               if (fifo_data !== exp) begin
                  errors++;
                  $display("FAIL sb_data: got %h, expected %h", fifo_data, exp);
               end
            end
            frame_words++;
         end
         if (send_start) begin
            checks++;
            if (fifo_we !== 1'b1 || frame_words != LedNum) begin
               errors++;
               $display("FAIL frame_len: we=%b words=%0d, expected we=1 words=%0d",
                        fifo_we, frame_words, LedNum);
            end
            frame_words = 0;
            starts++;
            start_cyc = cyc;
         end
         if (cap_ready && cpu_ready) begin
            errors++;
            $display("FAIL both_ready: got 1, expected 0");
         end
         if (cap_valid && cap_ready) sb_q.push_back(cap_data);
         if (cpu_valid && cpu_ready) sb_q.push_back(cpu_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic pulse_done();
      send_done = 1'b1;
      tick();
      send_done = 1'b0;
   endtask

   task automatic wait_gnt(input int budget, input string name);
      int i;
      for (i = 0; i < budget; i++) begin
         if (cap_gnt || cpu_gnt) break;
         tick();
      end
      checks++;
      if (i == budget) begin
         errors++;
         $display("FAIL %s_gnt_timeout: no grant, expected grant within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_start(input int budget, input string name);
      int s0 = starts;
      int i;
      for (i = 0; i < budget; i++) begin
         if (starts != s0) break;
         tick();
      end
      checks++;
      if (i == budget) begin
         errors++;
         $display("FAIL %s_start_timeout: no send_start, expected within %0d cycles", name, budget);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      logic [19:0] v;
      v = {cap_gnt, cpu_gnt, cap_ready, cpu_ready, fifo_we, send_start, busy, err_timeout,
           fifo_data};
      checks++;
      if (v !== '0) begin
         errors++;
         $display("FAIL %s: outputs %h, expected 0", name, v);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      check_outputs_zero("reset_async");
      do_reset();
      check_outputs_zero("reset_release");
   endtask

   task automatic test_single_frame();
      do_reset();
      en = 1'b1;
      cap_req = 1'b1;
      wait_gnt(20, "single");
      checks++;
      if (cap_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
         errors++;
         $display("FAIL single_gnt: cap=%b cpu=%b, expected cap=1 cpu=0", cap_gnt, cpu_gnt);
      end
      cap_req = 1'b0;
      wait_start(200, "single");
      checks++;
      if (send_start !== 1'b0 || fifo_we !== 1'b0 || cap_gnt !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_after: start=%b we=%b gnt=%b busy=%b, expected 0 0 0 1",
                  send_start, fifo_we, cap_gnt, busy);
      end
      repeat (4) tick();
      pulse_done();
      checks++;
      if (busy !== 1'b0 || sb_q.size() != 0) begin
         errors++;
         $display("FAIL single_idle: busy=%b q=%0d, expected 0 0", busy, sb_q.size());
      end
   endtask

   task automatic test_arbitration();
      do_reset();
      en = 1'b1;
      cap_req = 1'b1;
      cpu_req = 1'b1;
      for (int f = 0; f < 3; f++) begin
         logic exp_cap;
         exp_cap = (f != 1);
         wait_gnt(1200, "arb");
         checks++;
         if (cpu_gnt !== 1'b1 || cap_gnt !== 1'b0) begin
            errors++;
            $display("FAIL arb_fixed_%0d: cap=%b cpu=%b, expected cap=0 cpu=1", f, cap_gnt, cpu_gnt);
         end
         checks++;
         if (rr_cap_gnt !== exp_cap || rr_cpu_gnt !== !exp_cap) begin
            errors++;
            $display("FAIL arb_rr_%0d: cap=%b cpu=%b, expected cap=%b cpu=%b",
                     f, rr_cap_gnt, rr_cpu_gnt, exp_cap, !exp_cap);
         end
         if (f == 2) begin
            cap_req = 1'b0;
            cpu_req = 1'b0;
         end
         wait_start(200, "arb");
         repeat (5) tick();
         pulse_done();
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      en = 1'b1;
      cap_req = 1'b1;
      wait_gnt(20, "bp");
      cap_req = 1'b0;
      repeat (15) tick();
      fifo_afull = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++;
         if (cap_ready !== 1'b0 || (i > 0 && fifo_we !== 1'b0)) begin
            errors++;
            $display("FAIL bp_stall_%0d: ready=%b we=%b, expected ready=0 we=0", i, cap_ready, fifo_we);
         end
         tick();
      end
      fifo_afull = 1'b0;
      wait_start(200, "bp");
      repeat (3) tick();
      pulse_done();
   endtask

   task automatic test_frame_gap();
      int first_start;
      do_reset();
      en = 1'b1;
      cap_req = 1'b1;
      wait_gnt(20, "gap");
      wait_start(200, "gap");
      first_start = start_cyc;
      repeat (99) tick();
      pulse_done();
      wait_gnt(1500, "gap2");
      checks++;
      if (cyc - first_start < 1000 || cyc - first_start > 1001) begin
         errors++;
         $display("FAIL gap_interval: got %0d cycles, expected 1000..1001", cyc - first_start);
      end
      cap_req = 1'b0;
      wait_start(200, "gap2");
      pulse_done();
   endtask

   task automatic test_timeout();
      int s;
      do_reset();
      en = 1'b1;
      cap_req = 1'b1;
      wait_gnt(20, "to");
      cap_req = 1'b0;
      wait_start(200, "to");
      s = start_cyc;
      for (int i = 0; i < 600 && cyc < s + 499; i++) tick();
      checks++;
      if (err_timeout !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL to_early: err=%b busy=%b at +%0d, expected err=0 busy=1",
                  err_timeout, busy, cyc - s);
      end
      tick();
      checks++;
      if (err_timeout !== 1'b1 || busy !== 1'b0 || cyc != s + 500) begin
         errors++;
         $display("FAIL to_fire: err=%b busy=%b at +%0d, expected err=1 busy=0 at +500",
                  err_timeout, busy, cyc - s);
      end
      pulse_done();
      repeat (3) tick();
      checks++;
      if (err_timeout !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL to_sticky: err=%b busy=%b, expected err=1 busy=0", err_timeout, busy);
      end
      do_reset();
      checks++;
      if (err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL to_clear: err=%b, expected 0", err_timeout);
      end
   endtask

   task automatic test_enable_and_reset();
      bit seen;
      do_reset();
      en = 1'b0;
      cap_req = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         if (cap_gnt || cpu_gnt || busy) seen = 1'b1;
         tick();
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL en_idle: grant seen=1, expected 0");
      end
      en = 1'b1;
      valid_rand = 1'b1;
      wait_gnt(20, "en");
      cap_req = 1'b0;
      repeat (10) tick();
      en = 1'b0;
      wait_start(400, "en_mid");
      en = 1'b1;
      pulse_done();
      do_reset();
      cap_req = 1'b1;
      wait_gnt(20, "rst");
      cap_req = 1'b0;
      for (int i = 0; i < 200 && frame_words < 20; i++) tick();
      checks++;
      if (frame_words != 20) begin
         errors++;
         $display("FAIL rst_word20: got %0d words, expected 20", frame_words);
      end
      rst = 1'b1;
      #1;
      check_outputs_zero("rst_midframe");
      tick();
      rst = 1'b0;
      tick();
      cap_req = 1'b1;
      wait_gnt(20, "rst2");
      cap_req = 1'b0;
      wait_start(400, "rst2");
      pulse_done();
      valid_rand = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_arbitration();
      test_backpressure();
      test_frame_gap();
      test_timeout();
      test_enable_and_reset();
      tick();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d words, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
